// File: rtl/mem_port_arbiter.sv
// Purpose : shares one memory port between fetch (i_*) and load/store (d_*) masters,
//           data priority with fetch promotion after STARVE_LIMIT losing cycles.
// Latency : 0 cycles on both request and response paths (combinational forwarding).
// Backpr. : m_req is withheld while MAX_OUTSTANDING responses are pending; the selection
//           is held (locked) until the slave grants.
// Ports   : clk/rst_n; fetch i_req/i_addr -> i_grnt, i_valid/i_rdata;
//           data d_req/d_addr/d_wdata/d_wen/d_ren/d_beat -> d_grnt, d_valid/d_rdata;
//           memory m_req/m_addr/m_wdata/m_wen/m_ren/m_beat <- m_grnt, m_valid/m_rdata;
//           err_unexpected: sticky flag for a response with nothing outstanding.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int BEAT_SIZE       = 8,
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_req,
  output logic                             i_grnt,
  input  logic [ADDR_WIDTH-1:0]            i_addr,
  output logic                             i_valid,
  output logic [DATA_WIDTH-1:0]            i_rdata,
  input  logic                             d_req,
  output logic                             d_grnt,
  input  logic [ADDR_WIDTH-1:0]            d_addr,
  input  logic [DATA_WIDTH-1:0]            d_wdata,
  input  logic                             d_wen,
  input  logic                             d_ren,
  input  logic [DATA_WIDTH/BEAT_SIZE-1:0]  d_beat,
  output logic                             d_valid,
  output logic [DATA_WIDTH-1:0]            d_rdata,
  output logic                             m_req,
  input  logic                             m_grnt,
  output logic [ADDR_WIDTH-1:0]            m_addr,
  output logic [DATA_WIDTH-1:0]            m_wdata,
  output logic                             m_wen,
  output logic                             m_ren,
  output logic [DATA_WIDTH/BEAT_SIZE-1:0]  m_beat,
  input  logic                             m_valid,
  input  logic [DATA_WIDTH-1:0]            m_rdata,
  output logic                             err_unexpected
);

  localparam int BEAT_W = DATA_WIDTH / BEAT_SIZE;
  localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int STV_W  = 4;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

  // State
  logic                       lock_q, lock_d;
  logic                       lock_sel_q, lock_sel_d;   // 0 = fetch, 1 = data
  logic [STV_W-1:0]           starve_q, starve_d;
  logic [MAX_OUTSTANDING-1:0] own_q, own_d;             // owner of each outstanding txn
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       err_q, err_d;

  // Combinational
  logic sel, sel_req, promote, fifo_full, fifo_empty, xfer, pop, head;

  always_comb begin
    promote    = (starve_q == STV_MAX);
    fifo_full  = (cnt_q == CNT_MAX);
    fifo_empty = (cnt_q == '0);

    // Selection: a pending un-granted request keeps its slot via the lock.
    if (lock_q)                         sel = lock_sel_q;
    else if (d_req && !(promote && i_req)) sel = 1'b1;
    else                                sel = 1'b0;

    sel_req = sel ? d_req : i_req;
    m_req   = sel_req & ~fifo_full;
    xfer    = m_req & m_grnt;
    i_grnt  = xfer & ~sel;
    d_grnt  = xfer & sel;

    // Fetch's fixed read attributes are qualified by i_req so an idle port drives zeros.
    m_addr  = sel ? d_addr  : i_addr;
    m_wdata = sel ? d_wdata : '0;
    m_wen   = sel ? d_wen   : 1'b0;
    m_ren   = sel ? d_ren   : i_req;
    m_beat  = sel ? d_beat  : {BEAT_W{i_req}};

    // Response routing from the in-order owner FIFO head.
    pop     = m_valid & ~fifo_empty;
    head    = own_q[rd_ptr_q];
    i_valid = pop & ~head;
    d_valid = pop & head;
    i_rdata = m_rdata;
    d_rdata = m_rdata;
    err_unexpected = err_q;

    // Next state, defaults first.
    lock_d     = lock_q;
    lock_sel_d = lock_sel_q;
    starve_d   = starve_q;
    own_d      = own_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    err_d      = err_q | (m_valid & fifo_empty);

    if (xfer) begin
      lock_d = 1'b0;
    end else if (m_req && !m_grnt) begin
      lock_d     = 1'b1;
      lock_sel_d = sel;
    end

    if (!i_req || i_grnt)       starve_d = '0;
    else if (starve_q != STV_MAX) starve_d = starve_q + STV_W'(1);

    // xfer already excludes the full case, so a same-cycle pop never frees a slot early.
    if (xfer) begin
      own_d[wr_ptr_q] = sel;
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (xfer && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (pop && !xfer) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q     <= 1'b0;
      lock_sel_q <= 1'b0;
      starve_q   <= '0;
      own_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
      starve_q   <= starve_d;
      own_q      <= own_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

endmodule
